// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared types for the ping-pong sample buffer.
//   bank_state_e : lifecycle of one RAM bank
//                  FREE -> FILLING -> FULL -> READING -> FREE
package pingpong_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_e;

  // True when a bank holds a block that has not been fully consumed yet.
  function automatic logic bank_busy(bank_state_e s);
    return (s == FULL) || (s == READING);
  endfunction

endpackage

// File: rtl/pingpong_buffer_sp_if.sv
// pingpong_buffer_sp_if: write stream, read stream, block handshake and
// status flags of the ping-pong buffer.
//   slave  : buffer side (consumes wr_*, rd_ready_i, buf_take_i)
//   master : environment side (source + consumer)
// Signal suffixes are given from the buffer's point of view.
interface pingpong_buffer_sp_if #(
  parameter int SAMPLE_W = 16
);
  // write stream
  logic [SAMPLE_W-1:0] wr_data_i;
  logic                wr_valid_i;
  logic                wr_ready_o;
  logic                sample_ready_i;
  logic                frame_start_i;
  // read stream
  logic [SAMPLE_W-1:0] rd_data_o;
  logic                rd_valid_o;
  logic                rd_ready_i;
  logic                rd_last_o;
  // block handshake / status
  logic                buf_ready_o;
  logic                buf_id_o;
  logic                buf_take_i;
  logic                buf_empty_o;
  logic                overrun_o;
  logic                underrun_o;

  modport slave (
    input  wr_data_i, wr_valid_i, sample_ready_i, frame_start_i,
    input  rd_ready_i, buf_take_i,
    output wr_ready_o, rd_data_o, rd_valid_o, rd_last_o,
    output buf_ready_o, buf_id_o, buf_empty_o, overrun_o, underrun_o
  );

  modport master (
    output wr_data_i, wr_valid_i, sample_ready_i, frame_start_i,
    output rd_ready_i, buf_take_i,
    input  wr_ready_o, rd_data_o, rd_valid_o, rd_last_o,
    input  buf_ready_o, buf_id_o, buf_empty_o, overrun_o, underrun_o
  );
endinterface

// File: rtl/pingpong_sp_ram.sv
// pingpong_sp_ram: single-port synchronous RAM, one access per cycle.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write wdata to addr, 0 = read addr
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access; holds its value
//           across writes and idle cycles
// Storage is not reset.
module pingpong_sp_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/pingpong_buffer_sp.sv
// pingpong_buffer_sp: two-bank sample buffer on one single-port RAM.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : pingpong_buffer_sp_if.slave
//            write side  - wr_data_i/wr_valid_i/wr_ready_o, sample_ready_i,
//                          frame_start_i
//            block side  - buf_ready_o/buf_id_o/buf_take_i
//            read side   - rd_data_o/rd_valid_o/rd_ready_i/rd_last_o
//            status      - buf_empty_o, overrun_o, underrun_o
// The source fills bank wb; a full bank is offered as bank rb, claimed with
// buf_take_i and streamed out through a 2-entry FIFO that absorbs the RAM
// read latency. Writes own the RAM port; read fetches use idle cycles.
module pingpong_buffer_sp
  import pingpong_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int BUF_LEN  = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pingpong_buffer_sp_if.slave  bus
);

  localparam int IDX_W  = $clog2(BUF_LEN);
  localparam int ADDR_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BUF_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  // bank bookkeeping
  bank_state_e        bank_q [2];
  bank_state_e        bank_d [2];
  logic               wb_q, wb_d;
  logic               rb_q, rb_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  // read fetch pointer into bank rb
  logic [IDX_W-1:0]   fidx_q, fidx_d;
  logic               fdone_q, fdone_d;
  // fetch issued last cycle, RAM data lands this cycle
  logic               rvld_q, rvld_d;
  logic               rlast_q, rlast_d;
  // 2-entry output FIFO
  logic [SAMPLE_W-1:0] fdata_q [2];
  logic [SAMPLE_W-1:0] fdata_d [2];
  logic                flast_q [2];
  logic                flast_d [2];
  logic                frd_q, frd_d;
  logic                fwr_q, fwr_d;
  logic [1:0]          fcnt_q, fcnt_d;
  // registered status
  logic               buf_ready_q, buf_ready_d;
  logic               buf_empty_q, buf_empty_d;
  logic               overrun_q, overrun_d;
  logic               underrun_q, underrun_d;

  // combinational
  logic               wr_ready;
  logic               wr_acc;
  logic [IDX_W-1:0]   widx_base;
  logic               fetch;
  logic               pop;
  logic               ram_en;
  logic [ADDR_W-1:0]  ram_addr;
  logic [SAMPLE_W-1:0] ram_rdata;

  pingpong_sp_ram #(
    .DEPTH (2 * BUF_LEN),
    .WIDTH (SAMPLE_W),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (wr_acc),
    .addr  (ram_addr),
    .wdata (bus.wr_data_i),
    .rdata (ram_rdata)
  );

  always_comb begin
    wr_ready  = (bank_q[wb_q] == FREE) || (bank_q[wb_q] == FILLING);
    wr_acc    = bus.wr_valid_i & bus.sample_ready_i & wr_ready;
    // frame_start rewinds the fill; a same-cycle write lands at index 0
    widx_base = bus.frame_start_i ? '0 : widx_q;
    pop       = (fcnt_q != 2'd0) & bus.rd_ready_i;
    // Only fetch if the word is guaranteed a FIFO slot when it arrives,
    // counting the word already in flight and any word leaving now.
    fetch     = (bank_q[rb_q] == READING) & ~fdone_q & ~wr_acc &
                ((int'(fcnt_q) + int'(rvld_q) - int'(pop)) < 2);
    ram_en    = wr_acc | fetch;
    ram_addr  = wr_acc ? {wb_q, widx_base} : {rb_q, fidx_q};
  end

  always_comb begin
    bank_d      = bank_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    widx_d      = widx_q;
    fidx_d      = fidx_q;
    fdone_d     = fdone_q;
    fdata_d     = fdata_q;
    flast_d     = flast_q;
    frd_d       = frd_q;
    fwr_d       = fwr_q;
    rvld_d      = fetch;
    rlast_d     = fetch & (fidx_q == IDX_MAX);

    // write side
    if (bus.frame_start_i) widx_d = '0;
    if (wr_acc) begin
      if (widx_base == IDX_MAX) begin
        bank_d[wb_q] = FULL;
        widx_d       = '0;
        wb_d         = ~wb_q;
      end else begin
        bank_d[wb_q] = FILLING;
        widx_d       = widx_base + IDX_ONE;
      end
    end

    // claim: only possible while no bank is READING, so it never collides
    // with the end-of-block release below
    if (bus.buf_take_i & buf_ready_q) begin
      bank_d[rb_q] = READING;
      fidx_d       = '0;
      fdone_d      = 1'b0;
    end

    if (fetch) begin
      fidx_d = fidx_q + IDX_ONE;
      if (fidx_q == IDX_MAX) fdone_d = 1'b1;
    end

    // output FIFO
    if (rvld_q) begin
      fdata_d[fwr_q] = ram_rdata;
      flast_d[fwr_q] = rlast_q;
      fwr_d          = ~fwr_q;
    end
    if (pop) begin
      frd_d = ~frd_q;
      if (flast_q[frd_q]) begin
        bank_d[rb_q] = FREE;
        rb_d         = ~rb_q;
      end
    end
    fcnt_d = fcnt_q + {1'b0, rvld_q} - {1'b0, pop};

    // status flags reflect the post-update bank states
    buf_ready_d = (bank_d[rb_d] == FULL) &
                  (bank_d[0] != READING) & (bank_d[1] != READING);
    buf_empty_d = ~(bank_busy(bank_d[0]) | bank_busy(bank_d[1]));
    overrun_d   = bus.wr_valid_i & bus.sample_ready_i & ~wr_ready;
    underrun_d  = bus.buf_take_i & ~buf_ready_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q[0]   <= FREE;
      bank_q[1]   <= FREE;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      widx_q      <= '0;
      fidx_q      <= '0;
      fdone_q     <= 1'b1;
      rvld_q      <= 1'b0;
      rlast_q     <= 1'b0;
      fdata_q[0]  <= '0;
      fdata_q[1]  <= '0;
      flast_q[0]  <= 1'b0;
      flast_q[1]  <= 1'b0;
      frd_q       <= 1'b0;
      fwr_q       <= 1'b0;
      fcnt_q      <= 2'd0;
      buf_ready_q <= 1'b0;
      buf_empty_q <= 1'b1;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      widx_q      <= widx_d;
      fidx_q      <= fidx_d;
      fdone_q     <= fdone_d;
      rvld_q      <= rvld_d;
      rlast_q     <= rlast_d;
      fdata_q     <= fdata_d;
      flast_q     <= flast_d;
      frd_q       <= frd_d;
      fwr_q       <= fwr_d;
      fcnt_q      <= fcnt_d;
      buf_ready_q <= buf_ready_d;
      buf_empty_q <= buf_empty_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.wr_ready_o  = wr_ready;
  assign bus.rd_valid_o  = (fcnt_q != 2'd0);
  assign bus.rd_data_o   = fdata_q[frd_q];
  assign bus.rd_last_o   = (fcnt_q != 2'd0) & flast_q[frd_q];
  assign bus.buf_ready_o = buf_ready_q;
  assign bus.buf_id_o    = rb_q;
  assign bus.buf_empty_o = buf_empty_q;
  assign bus.overrun_o   = overrun_q;
  assign bus.underrun_o  = underrun_q;

endmodule

// File: tb/tb_pingpong_buffer_sp.sv
// tb_pingpong_buffer_sp: scoreboard bench. A negedge monitor models bank
// occupancy, pushes each completed block into exp_q and pops/compares every
// read transfer; directed tasks drive the write source and block consumer.
module tb_pingpong_buffer_sp;

  localparam int SAMPLE_W = 16;
  localparam int BUF_LEN  = 256;

  typedef struct {
    logic [SAMPLE_W-1:0] d;
    logic                last;
  } exp_t;

  logic clk;
  logic rst_n;

  pingpong_buffer_sp_if #(.SAMPLE_W(SAMPLE_W)) bus ();

  pingpong_buffer_sp #(.SAMPLE_W(SAMPLE_W), .BUF_LEN(BUF_LEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // model state
  exp_t                exp_q[$];
  logic [SAMPLE_W-1:0] pend[$];
  exp_t                e;
  int                  held      = 0;   // banks FULL or READING
  int                  rd_blocks = 0;
  int                  stall_cnt = 0;
  logic                wr_acc_m  = 1'b0;
  logic                ovr_exp   = 1'b0;
  logic                stall_prev = 1'b0;
  logic [SAMPLE_W-1:0] prev_data = '0;
  logic                prev_last = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("buf_empty", bus.buf_empty_o, held == 0);
      chk("overrun", bus.overrun_o, ovr_exp);
      if (bus.wr_valid_i && bus.sample_ready_i) begin
        chk("wr_ready", bus.wr_ready_o, held < 2);
        if (!bus.wr_ready_o) stall_cnt++;
      end
      if (stall_prev) begin
        chk("hold_valid", bus.rd_valid_o, 1);
        chk("hold_data", bus.rd_data_o, prev_data);
        chk("hold_last", bus.rd_last_o, prev_last);
      end
      wr_acc_m = bus.wr_valid_i && bus.sample_ready_i && (held < 2);
      ovr_exp  = bus.wr_valid_i && bus.sample_ready_i && !(held < 2);
      if (bus.frame_start_i) pend.delete();
      if (wr_acc_m) begin
        pend.push_back(bus.wr_data_i);
        if (pend.size() == BUF_LEN) begin
          foreach (pend[j]) begin
            e.d = pend[j];
            e.last = (j == BUF_LEN - 1);
            exp_q.push_back(e);
          end
          pend.delete();
          held++;
        end
      end
      if (bus.rd_valid_o && bus.rd_ready_i) begin
        if (exp_q.size() == 0) chk("rd_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("rd_data", bus.rd_data_o, e.d);
          chk("rd_last", bus.rd_last_o, e.last);
          if (e.last) begin
            held--;
            rd_blocks++;
          end
        end
      end
      stall_prev = bus.rd_valid_o && !bus.rd_ready_i;
      prev_data  = bus.rd_data_o;
      prev_last  = bus.rd_last_o;
    end
  end

  task automatic idle_inputs();
    bus.wr_data_i      = '0;
    bus.wr_valid_i     = 1'b0;
    bus.sample_ready_i = 1'b1;
    bus.frame_start_i  = 1'b0;
    bus.rd_ready_i     = 1'b0;
    bus.buf_take_i     = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    pend.delete();
    held = 0; ovr_exp = 1'b0; stall_prev = 1'b0; wr_acc_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rd_valid", bus.rd_valid_o, 0);
    chk("rst_rd_last", bus.rd_last_o, 0);
    chk("rst_rd_data", bus.rd_data_o, 0);
    chk("rst_buf_ready", bus.buf_ready_o, 0);
    chk("rst_buf_id", bus.buf_id_o, 0);
    chk("rst_buf_empty", bus.buf_empty_o, 1);
    chk("rst_overrun", bus.overrun_o, 0);
    chk("rst_underrun", bus.underrun_o, 0);
    chk("rst_wr_ready", bus.wr_ready_o, 1);
    @(posedge clk); #1;
  endtask

  // Writes n samples base, base+1, ... ; gap = percent of idle/unqualified
  // cycles inserted; fs raises frame_start_i with the first sample.
  task automatic write_words(input logic [SAMPLE_W-1:0] base, input int n,
                             input int gap, input bit fs);
    int t;
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        bus.wr_valid_i     = 1'($urandom_range(0, 1));
        bus.sample_ready_i = 1'b0;
        bus.frame_start_i  = 1'b0;
        bus.wr_data_i      = 16'hDEAD;
        @(posedge clk); #1;
      end
      bus.wr_valid_i     = 1'b1;
      bus.sample_ready_i = 1'b1;
      bus.wr_data_i      = base + SAMPLE_W'(i);
      bus.frame_start_i  = fs && (i == 0);
      t = 0;
      do begin
        @(posedge clk); #1;
        t++;
      end while (!wr_acc_m && t < 5000);
      if (!wr_acc_m) begin
        chk("wr_timeout", wr_acc_m, 1);
        break;
      end
    end
    bus.wr_valid_i    = 1'b0;
    bus.frame_start_i = 1'b0;
    bus.sample_ready_i = 1'b1;
  endtask

  // Waits for an offered block, checks its id, claims it and drains it with
  // bp percent of backpressure (low stretches of 1..5 cycles).
  task automatic read_block(input logic exp_id, input int bp, input bit lat);
    int n;
    int start;
    int hold;
    n = 0;
    @(negedge clk);
    while (!bus.buf_ready_o && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("buf_ready", bus.buf_ready_o, 1);
    chk("buf_id", bus.buf_id_o, exp_id);
    start = rd_blocks;
    @(posedge clk); #1 bus.buf_take_i = 1'b1;
    @(posedge clk); #1 bus.buf_take_i = 1'b0;
    @(negedge clk);
    n = 1;
    chk("buf_ready_drop", bus.buf_ready_o, 0);
    while (!bus.rd_valid_o && n < 3) begin
      @(negedge clk);
      n++;
    end
    if (lat) chk("rd_latency", bus.rd_valid_o, 1);
    @(posedge clk); #1;
    n = 0;
    hold = 0;
    while (rd_blocks == start && n < 20000) begin
      if (hold > 0) begin
        bus.rd_ready_i = 1'b0;
        hold--;
      end else if (bp > 0 && $urandom_range(0, 99) < bp) begin
        bus.rd_ready_i = 1'b0;
        hold = $urandom_range(0, 4);
      end else begin
        bus.rd_ready_i = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.rd_ready_i = 1'b0;
    chk("rd_block_done", rd_blocks - start, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // single block
    do_reset();
    write_words(16'h1000, BUF_LEN, 0, 1'b0);
    read_block(1'b0, 0, 1'b1);

    // ping-pong, writer streams two blocks back to back
    do_reset();
    stall_cnt = 0;
    fork
      begin
        write_words(16'h2000, BUF_LEN, 0, 1'b0);
        write_words(16'h3000, BUF_LEN, 0, 1'b0);
      end
      begin
        read_block(1'b0, 0, 1'b0);
        read_block(1'b1, 0, 1'b0);
      end
    join
    chk("pp_no_stall", stall_cnt, 0);

    // read backpressure
    do_reset();
    fork
      write_words(16'h4000, BUF_LEN, 0, 1'b0);
      read_block(1'b0, 30, 1'b0);
    join

    // overrun: both banks full, source keeps pushing
    do_reset();
    write_words(16'h5000, BUF_LEN, 0, 1'b0);
    write_words(16'h6000, BUF_LEN, 0, 1'b0);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 16'h7000;
    repeat (10) begin
      @(negedge clk);
      chk("ovr_wr_ready", bus.wr_ready_o, 0);
    end
    chk("ovr_flag", bus.overrun_o, 1);
    @(posedge clk); #1 bus.wr_valid_i = 1'b0;
    read_block(1'b0, 0, 1'b0);
    read_block(1'b1, 0, 1'b0);

    // streaming, 4 blocks concurrently
    do_reset();
    fork
      begin
        write_words(16'h8000, BUF_LEN, 50, 1'b0);
        write_words(16'h8400, BUF_LEN, 50, 1'b0);
        write_words(16'h8800, BUF_LEN, 50, 1'b0);
        write_words(16'h8C00, BUF_LEN, 50, 1'b0);
      end
      begin
        read_block(1'b0, 0, 1'b0);
        read_block(1'b1, 0, 1'b0);
        read_block(1'b0, 0, 1'b0);
        read_block(1'b1, 0, 1'b0);
      end
    join

    // reset with one full and one partial bank
    do_reset();
    write_words(16'hC000, BUF_LEN + 40, 0, 1'b0);
    do_reset();

    // take with nothing offered
    bus.buf_take_i = 1'b1;
    @(posedge clk); #1 bus.buf_take_i = 1'b0;
    @(negedge clk);
    chk("underrun_pulse", bus.underrun_o, 1);
    chk("underrun_no_offer", bus.buf_ready_o, 0);
    @(negedge clk);
    chk("underrun_clear", bus.underrun_o, 0);
    chk("underrun_id", bus.buf_id_o, 0);
    @(posedge clk); #1;

    // frame_start mid-fill discards the partial fill
    write_words(16'hB000, 10, 0, 1'b0);
    write_words(16'hB100, BUF_LEN, 0, 1'b1);
    read_block(1'b0, 0, 1'b0);

    // random gaps on both sides
    fork
      write_words(16'hA000, BUF_LEN, 30, 1'b0);
      read_block(1'b1, 30, 1'b0);
    join

    repeat (4) @(posedge clk);
    chk("sb_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
